// File: rtl/pipeline_perf_mon.sv
// Performance-event counter unit: counts per-cycle pipeline events over a programmable
// window, snapshots the totals when the window closes, and serves them on a registered read port.
module pipeline_perf_mon #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int SAT     = 0,
    parameter int SEL_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               start,
    input  logic               stop,
    input  logic               clr,
    input  logic [CNT_W-1:0]   win_len,
    input  logic [SEL_W-1:0]   rd_sel,
    input  logic               rd_snap,
    output logic [CNT_W-1:0]   rd_data,
    output logic               busy,
    output logic               done
);
    // Channel NUM_EVT is the cycle counter, so it shares the event-counter datapath.
    localparam int NCH = NUM_EVT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] win_len_q, win_len_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             count_en, live_clr, snap_clr, snap_en, expire;
    logic [NCH-1:0]   inc_req, ovf_live, ovf_snap;
    logic [CNT_W-1:0] live_cnt [NCH];
    logic [CNT_W-1:0] live_nxt [NCH];
    logic [CNT_W-1:0] snap_cnt [NCH];

    assign inc_req  = {1'b1, evt};
    assign live_clr = clr | start;
    assign snap_clr = clr;
    assign count_en = (state_q == RUN) && !clr && !start;
    assign expire   = (win_len_q != '0) && (live_nxt[NUM_EVT] == win_len_q);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d;
            logic             ovf_q, ovf_d, sovf_q, sovf_d;

            always_comb begin
                cnt_d = cnt_q;
                ovf_d = ovf_q;
                if (live_clr) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (count_en && inc_req[gi]) begin
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                        cnt_d = (SAT != 0) ? cnt_q : '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Snapshot captures the post-increment value so the closing cycle is included.
            always_comb begin
                snap_d = snap_q;
                sovf_d = sovf_q;
                if (snap_clr) begin
                    snap_d = '0;
                    sovf_d = 1'b0;
                end else if (snap_en) begin
                    snap_d = cnt_d;
                    sovf_d = ovf_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                    snap_q <= '0;
                    sovf_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    ovf_q  <= ovf_d;
                    snap_q <= snap_d;
                    sovf_q <= sovf_d;
                end
            end

            assign live_cnt[gi] = cnt_q;
            assign live_nxt[gi] = cnt_d;
            assign snap_cnt[gi] = snap_q;
            assign ovf_live[gi] = ovf_q;
            assign ovf_snap[gi] = sovf_q;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        win_len_d = win_len_q;
        snap_en   = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else if (start) begin
            state_d   = RUN;
            win_len_d = win_len;
        end else if (state_q == RUN && (stop || expire)) begin
            state_d = DONE;
            snap_en = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_sel == '0) begin
            rd_data_d = rd_snap ? snap_cnt[NUM_EVT] : live_cnt[NUM_EVT];
        end
        for (int i = 0; i < NUM_EVT; i++) begin
            if (rd_sel == SEL_W'(i + 1)) begin
                rd_data_d = rd_snap ? snap_cnt[i] : live_cnt[i];
            end
        end
        if (rd_sel == SEL_W'(NUM_EVT + 1)) begin
            rd_data_d = CNT_W'(rd_snap ? ovf_snap : ovf_live);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            win_len_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            win_len_q <= win_len_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule
